bp_fe_pred_update_arb: RTL and testbench



---
 rtl/bp_fe_pred_update_arb_if.sv | 54 +++++
 rtl/bp_fe_pred_update_arb.sv | 145 ++++++++++++++
 tb/tb_bp_fe_pred_update_arb.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_fe_pred_update_arb_if.sv
// Handshake bundle between the redirect/attaboy producers, the
// predictor write port and the update arbiter.
interface bp_fe_pred_update_arb_if
  #(parameter int vaddr_width_p               = 39
   ,parameter int branch_metadata_fwd_width_p = 64
   );

  logic                                   init_done_i;

  logic                                   redir_v_i;
  logic                                   redir_taken_i;
  logic                                   redir_nonbr_i;
  logic [vaddr_width_p-1:0]               redir_pc_i;
  logic [branch_metadata_fwd_width_p-1:0] redir_md_i;

  logic                                   attaboy_v_i;
  logic                                   attaboy_taken_i;
  logic [vaddr_width_p-1:0]               attaboy_pc_i;
  logic [branch_metadata_fwd_width_p-1:0] attaboy_md_i;
  logic                                   attaboy_yumi_o;

  logic                                   upd_v_o;
  logic                                   upd_src_o;
  logic [vaddr_width_p-1:0]               upd_pc_o;
  logic [branch_metadata_fwd_width_p-1:0] upd_md_o;
  logic                                   upd_taken_o;
  logic                                   upd_nonbr_o;
  logic                                   upd_yumi_i;

  logic                                   drop_o;

  // arbiter side
  modport slave
    (input  init_done_i
    ,input  redir_v_i, redir_taken_i, redir_nonbr_i, redir_pc_i, redir_md_i
    ,input  attaboy_v_i, attaboy_taken_i, attaboy_pc_i, attaboy_md_i
    ,output attaboy_yumi_o
    ,output upd_v_o, upd_src_o, upd_pc_o, upd_md_o, upd_taken_o, upd_nonbr_o
    ,input  upd_yumi_i
    ,output drop_o
    );

  // producer / predictor side
  modport master
    (output init_done_i
    ,output redir_v_i, redir_taken_i, redir_nonbr_i, redir_pc_i, redir_md_i
    ,output attaboy_v_i, attaboy_taken_i, attaboy_pc_i, attaboy_md_i
    ,input  attaboy_yumi_o
    ,input  upd_v_o, upd_src_o, upd_pc_o, upd_md_o, upd_taken_o, upd_nonbr_o
    ,output upd_yumi_i
    ,input  drop_o
    );

endinterface

// File: rtl/bp_fe_pred_update_arb.sv
// Shares the single predictor write port between redirect training
// (one-entry overwriting hold) and attaboy training (small FIFO).
// Redirects win by default; an attaboy head that waits too long forces
// one attaboy grant through.
//
// state    | meaning
// e_init   | BTB/BHT still initializing; nothing accepted, redirects dropped
// e_run    | normal arbitration, redirect hold has priority
// e_starve | attaboy head has waited starve_limit_p cycles; it goes next
module bp_fe_pred_update_arb
  #(parameter int vaddr_width_p               = 39
   ,parameter int branch_metadata_fwd_width_p = 64
   ,parameter int els_p                       = 4
   ,parameter int starve_limit_p              = 8
   )
  (input logic                     clk_i
  ,input logic                     reset_n_i
  ,bp_fe_pred_update_arb_if.slave  bus
  );

  localparam int ptr_w_lp    = $clog2(els_p);
  localparam int cnt_w_lp    = $clog2(els_p + 1);
  localparam int starve_w_lp = $clog2(starve_limit_p + 1);

  localparam logic [cnt_w_lp-1:0]    els_lp        = cnt_w_lp'(els_p);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

  typedef enum logic [1:0] {e_init, e_run, e_starve} state_e;

  state_e state_r, state_n;

  logic                                   hold_v_r;
  logic [vaddr_width_p-1:0]               hold_pc_r;
  logic [branch_metadata_fwd_width_p-1:0] hold_md_r;
  logic                                   hold_taken_r;
  logic                                   hold_nonbr_r;

  logic [vaddr_width_p-1:0]               fifo_pc_r [els_p];
  logic [branch_metadata_fwd_width_p-1:0] fifo_md_r [els_p];
  logic [els_p-1:0]                       fifo_taken_r;
  logic [ptr_w_lp-1:0]                    rptr_r, wptr_r;
  logic [cnt_w_lp-1:0]                    count_r;
  logic [starve_w_lp-1:0]                 starve_cnt_r;

  logic active, fifo_empty, fifo_full, sel_attaboy, upd_v;
  logic deq_attaboy, deq_hold, enq, redir_load;

  assign active      = (state_r != e_init);
  assign fifo_empty  = (count_r == '0);
  assign fifo_full   = (count_r == els_lp);
  // In e_starve the FIFO head is taken even over a valid hold.
  assign sel_attaboy = (state_r == e_starve) | ~hold_v_r;
  assign upd_v       = active & (sel_attaboy ? ~fifo_empty : hold_v_r);
  assign deq_attaboy = upd_v & bus.upd_yumi_i & sel_attaboy;
  assign deq_hold    = upd_v & bus.upd_yumi_i & ~sel_attaboy;
  // Gated by reset so a reset cycle never shows an accept or drop pulse.
  assign enq         = reset_n_i & active & bus.attaboy_v_i & (~fifo_full | deq_attaboy);
  assign redir_load  = active & bus.redir_v_i;

  assign bus.attaboy_yumi_o = enq;
  assign bus.drop_o = reset_n_i & bus.redir_v_i & (~active | (hold_v_r & ~deq_hold));
  assign bus.upd_v_o = upd_v;

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= e_init;
    else            state_r <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state_r;
    case (state_r)
      e_init:   if (bus.init_done_i) state_n = e_run;
      e_run:    if (starve_cnt_r == starve_max_lp && !deq_attaboy) state_n = e_starve;
      e_starve: if (deq_attaboy) state_n = e_run;
      default:  state_n = e_init;
    endcase
  end

  // Output payload straight from registered state, zero when idle
  always_comb begin
    bus.upd_src_o   = 1'b0;
    bus.upd_pc_o    = '0;
    bus.upd_md_o    = '0;
    bus.upd_taken_o = 1'b0;
    bus.upd_nonbr_o = 1'b0;
    if (upd_v) begin
      if (sel_attaboy) begin
        bus.upd_src_o   = 1'b1;
        bus.upd_pc_o    = fifo_pc_r[rptr_r];
        bus.upd_md_o    = fifo_md_r[rptr_r];
        bus.upd_taken_o = fifo_taken_r[rptr_r];
      end else begin
        bus.upd_pc_o    = hold_pc_r;
        bus.upd_md_o    = hold_md_r;
        bus.upd_taken_o = hold_taken_r;
        bus.upd_nonbr_o = hold_nonbr_r;
      end
    end
  end

  // Redirect hold, FIFO bookkeeping and starvation counter
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      hold_v_r     <= 1'b0;
      hold_pc_r    <= '0;
      hold_md_r    <= '0;
      hold_taken_r <= 1'b0;
      hold_nonbr_r <= 1'b0;
      rptr_r       <= '0;
      wptr_r       <= '0;
      count_r      <= '0;
      starve_cnt_r <= '0;
    end else begin
      if (redir_load) begin
        hold_v_r     <= 1'b1;
        hold_pc_r    <= bus.redir_pc_i;
        hold_md_r    <= bus.redir_md_i;
        hold_taken_r <= bus.redir_taken_i;
        hold_nonbr_r <= bus.redir_nonbr_i;
      end else if (deq_hold) begin
        hold_v_r <= 1'b0;
      end

      if (enq)         wptr_r <= wptr_r + ptr_w_lp'(1);
      if (deq_attaboy) rptr_r <= rptr_r + ptr_w_lp'(1);
      if (enq && !deq_attaboy)      count_r <= count_r + cnt_w_lp'(1);
      else if (!enq && deq_attaboy) count_r <= count_r - cnt_w_lp'(1);

      if (deq_attaboy || fifo_empty)      starve_cnt_r <= '0;
      else if (starve_cnt_r != starve_max_lp) starve_cnt_r <= starve_cnt_r + starve_w_lp'(1);
    end
  end

  // Attaboy FIFO storage; contents need no reset since occupancy guards reads
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_pc_r[wptr_r]    <= bus.attaboy_pc_i;
      fifo_md_r[wptr_r]    <= bus.attaboy_md_i;
      fifo_taken_r[wptr_r] <= bus.attaboy_taken_i;
    end
  end

endmodule

// File: tb/tb_bp_fe_pred_update_arb.sv
// Bench for the predictor update arbiter: a vector table, hand-written
// starvation and mid-reset sequences, then random traffic against a
// queue-based reference model.
module tb_bp_fe_pred_update_arb;

  localparam int VA     = 39;
  localparam int MD     = 64;
  localparam int ELS    = 4;
  localparam int STARVE = 8;
  localparam int NVEC   = 34;

  logic clk = 1'b0;
  logic reset_n;

  int n_pass  = 0;
  int n_total = 0;

  bp_fe_pred_update_arb_if #(.vaddr_width_p(VA), .branch_metadata_fwd_width_p(MD)) bus ();

  bp_fe_pred_update_arb #(
    .vaddr_width_p(VA), .branch_metadata_fwd_width_p(MD),
    .els_p(ELS), .starve_limit_p(STARVE)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  typedef struct {
    bit         init, rv, av, uy;
    bit         ev, esrc, eay, edrop;
    logic [VA-1:0] epc;
  } vec_t;

  typedef struct {
    logic [VA-1:0] pc;
    logic [MD-1:0] md;
    bit            taken;
    int            since;   // first cycle this entry sat at the head
  } rec_t;

  vec_t tbl [NVEC];

  // reference model state
  rec_t          q[$];
  bit            m_ready;
  bit            m_hold_v;
  logic [VA-1:0] m_hold_pc;
  logic [MD-1:0] m_hold_md;
  bit            m_hold_taken, m_hold_nonbr;
  int            cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.init_done_i     = 1'b0;
    bus.redir_v_i       = 1'b0;
    bus.redir_taken_i   = 1'b0;
    bus.redir_nonbr_i   = 1'b0;
    bus.redir_pc_i      = '0;
    bus.redir_md_i      = '0;
    bus.attaboy_v_i     = 1'b0;
    bus.attaboy_taken_i = 1'b0;
    bus.attaboy_pc_i    = '0;
    bus.attaboy_md_i    = '0;
    bus.upd_yumi_i      = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_upd_v"},  64'(bus.upd_v_o), 64'(0));
    chk({tag, "_ayumi"},  64'(bus.attaboy_yumi_o), 64'(0));
    chk({tag, "_drop"},   64'(bus.drop_o), 64'(0));
    chk({tag, "_pc"},     64'(bus.upd_pc_o), 64'(0));
    chk({tag, "_md"},     bus.upd_md_o, 64'(0));
    chk({tag, "_flags"},  64'({bus.upd_src_o, bus.upd_taken_o, bus.upd_nonbr_o}), 64'(0));
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk_idle_zero("reset");
  endtask

  // One cycle of the reference model: compare current outputs, then
  // advance the model as the coming clock edge will.
  task automatic model_cycle(input bit chk_zero);
    bit starving, pick_att, pick_red, ev, deq_att, deq_red, eay, edrop;
    rec_t r;
    starving = (q.size() > 0) && (cyc - q[0].since > STARVE);
    pick_att = (q.size() > 0) && (starving || !m_hold_v);
    pick_red = !pick_att && m_hold_v;
    ev       = m_ready && (pick_att || pick_red);
    deq_att  = ev && pick_att && bus.upd_yumi_i;
    deq_red  = ev && pick_red && bus.upd_yumi_i;
    eay      = reset_n && m_ready && bus.attaboy_v_i && (q.size() < ELS || deq_att);
    edrop    = reset_n && bus.redir_v_i && (!m_ready || (m_hold_v && !deq_red));

    chk("rnd_upd_v", 64'(bus.upd_v_o), 64'(ev));
    chk("rnd_ayumi", 64'(bus.attaboy_yumi_o), 64'(eay));
    chk("rnd_drop",  64'(bus.drop_o), 64'(edrop));
    if (ev && pick_att) begin
      chk("rnd_src",   64'(bus.upd_src_o), 64'(1));
      chk("rnd_pc",    64'(bus.upd_pc_o), 64'(q[0].pc));
      chk("rnd_md",    bus.upd_md_o, q[0].md);
      chk("rnd_taken", 64'(bus.upd_taken_o), 64'(q[0].taken));
      chk("rnd_nonbr", 64'(bus.upd_nonbr_o), 64'(0));
    end else if (ev) begin
      chk("rnd_src",   64'(bus.upd_src_o), 64'(0));
      chk("rnd_pc",    64'(bus.upd_pc_o), 64'(m_hold_pc));
      chk("rnd_md",    bus.upd_md_o, m_hold_md);
      chk("rnd_taken", 64'(bus.upd_taken_o), 64'(m_hold_taken));
      chk("rnd_nonbr", 64'(bus.upd_nonbr_o), 64'(m_hold_nonbr));
    end else if (chk_zero) begin
      chk("rnd_rst_pc", 64'(bus.upd_pc_o), 64'(0));
      chk("rnd_rst_md", bus.upd_md_o, 64'(0));
    end

    if (!reset_n) begin
      q.delete();
      m_hold_v = 1'b0;
      m_ready  = 1'b0;
    end else begin
      if (deq_att) begin
        void'(q.pop_front());
        if (q.size() > 0) q[0].since = cyc + 1;
      end
      if (eay) begin
        r.pc    = bus.attaboy_pc_i;
        r.md    = bus.attaboy_md_i;
        r.taken = bus.attaboy_taken_i;
        r.since = cyc + 1;
        q.push_back(r);
      end
      if (deq_red) m_hold_v = 1'b0;
      if (m_ready && bus.redir_v_i) begin
        m_hold_v     = 1'b1;
        m_hold_pc    = bus.redir_pc_i;
        m_hold_md    = bus.redir_md_i;
        m_hold_taken = bus.redir_taken_i;
        m_hold_nonbr = bus.redir_nonbr_i;
      end
      if (bus.init_done_i) m_ready = 1'b1;
    end
    cyc++;
  endtask

  initial begin
    logic [63:0] r64;
    bit          post_rst;
    int          uy_pct;

    // init, rv, av, uy | upd_v, src, ayumi, drop | pc
    tbl[0]  = '{0,0,0,0, 0,0,0,0, 39'h0};
    tbl[1]  = '{0,1,1,0, 0,0,0,1, 39'h0};
    tbl[2]  = '{0,0,0,0, 0,0,0,0, 39'h0};
    tbl[3]  = '{0,1,1,0, 0,0,0,1, 39'h0};
    tbl[4]  = '{0,0,0,0, 0,0,0,0, 39'h0};
    tbl[5]  = '{1,0,1,0, 0,0,0,0, 39'h0};
    tbl[6]  = '{1,0,1,0, 0,0,1,0, 39'h0};
    tbl[7]  = '{1,1,0,0, 1,1,0,0, 39'h2006};
    tbl[8]  = '{1,0,0,0, 1,0,0,0, 39'h1007};
    tbl[9]  = '{1,0,0,1, 1,0,0,0, 39'h1007};
    tbl[10] = '{1,0,0,0, 1,1,0,0, 39'h2006};
    tbl[11] = '{1,0,0,1, 1,1,0,0, 39'h2006};
    tbl[12] = '{1,0,0,0, 0,0,0,0, 39'h0};
    tbl[13] = '{1,0,1,0, 0,0,1,0, 39'h0};
    tbl[14] = '{1,0,1,0, 1,1,1,0, 39'h200d};
    tbl[15] = '{1,0,1,0, 1,1,1,0, 39'h200d};
    tbl[16] = '{1,0,1,0, 1,1,1,0, 39'h200d};
    tbl[17] = '{1,0,1,0, 1,1,0,0, 39'h200d};
    tbl[18] = '{1,0,1,1, 1,1,1,0, 39'h200d};
    tbl[19] = '{1,0,1,0, 1,1,0,0, 39'h200e};
    tbl[20] = '{1,0,0,1, 1,1,0,0, 39'h200e};
    tbl[21] = '{1,0,0,1, 1,1,0,0, 39'h200f};
    tbl[22] = '{1,0,0,1, 1,1,0,0, 39'h2010};
    tbl[23] = '{1,0,0,1, 1,1,0,0, 39'h2012};
    tbl[24] = '{1,0,0,0, 0,0,0,0, 39'h0};
    tbl[25] = '{1,1,0,0, 0,0,0,0, 39'h0};
    tbl[26] = '{1,1,0,0, 1,0,0,1, 39'h1019};
    tbl[27] = '{1,0,0,0, 1,0,0,0, 39'h101a};
    tbl[28] = '{1,0,0,1, 1,0,0,0, 39'h101a};
    tbl[29] = '{1,0,0,0, 0,0,0,0, 39'h0};
    tbl[30] = '{1,1,0,1, 0,0,0,0, 39'h0};
    tbl[31] = '{1,1,0,1, 1,0,0,0, 39'h101e};
    tbl[32] = '{1,0,0,1, 1,0,0,0, 39'h101f};
    tbl[33] = '{1,0,0,0, 0,0,0,0, 39'h0};

    // vector table: init gating, priority, FIFO full, redirect overwrite
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      bus.init_done_i     = tbl[i].init;
      bus.redir_v_i       = tbl[i].rv;
      bus.redir_pc_i      = 39'h1000 + VA'(i);
      bus.redir_md_i      = 64'(i);
      bus.redir_taken_i   = i[0];
      bus.redir_nonbr_i   = i[1];
      bus.attaboy_v_i     = tbl[i].av;
      bus.attaboy_pc_i    = 39'h2000 + VA'(i);
      bus.attaboy_md_i    = 64'(i) << 8;
      bus.attaboy_taken_i = i[0];
      bus.upd_yumi_i      = tbl[i].uy;
      #1;
      chk($sformatf("row%0d_upd_v", i), 64'(bus.upd_v_o), 64'(tbl[i].ev));
      chk($sformatf("row%0d_ayumi", i), 64'(bus.attaboy_yumi_o), 64'(tbl[i].eay));
      chk($sformatf("row%0d_drop", i),  64'(bus.drop_o), 64'(tbl[i].edrop));
      if (tbl[i].ev) begin
        chk($sformatf("row%0d_src", i), 64'(bus.upd_src_o), 64'(tbl[i].esrc));
        chk($sformatf("row%0d_pc", i),  64'(bus.upd_pc_o), 64'(tbl[i].epc));
      end
      tick();
    end

    // starvation: one attaboy waits behind a redirect every cycle
    do_reset();
    bus.init_done_i  = 1'b1;
    tick();
    bus.attaboy_v_i  = 1'b1;
    bus.attaboy_pc_i = 39'h3abc;
    bus.redir_v_i    = 1'b1;
    bus.redir_pc_i   = 39'h4000;
    bus.upd_yumi_i   = 1'b1;
    #1;
    chk("stv_enq_ayumi", 64'(bus.attaboy_yumi_o), 64'(1));
    chk("stv_enq_upd_v", 64'(bus.upd_v_o), 64'(0));
    tick();
    bus.attaboy_v_i = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      bus.redir_pc_i = 39'h4000 + VA'(k);
      #1;
      chk($sformatf("stv%0d_upd_v", k), 64'(bus.upd_v_o), 64'(1));
      if (k == 10) begin
        chk("stv10_src",  64'(bus.upd_src_o), 64'(1));
        chk("stv10_pc",   64'(bus.upd_pc_o), 64'(39'h3abc));
        chk("stv10_drop", 64'(bus.drop_o), 64'(1));
      end else begin
        chk($sformatf("stv%0d_src", k),  64'(bus.upd_src_o), 64'(0));
        chk($sformatf("stv%0d_pc", k),   64'(bus.upd_pc_o), 64'(39'h4000 + VA'(k - 1)));
        chk($sformatf("stv%0d_drop", k), 64'(bus.drop_o), 64'(0));
      end
      tick();
    end

    // reset in the middle of traffic: three queued attaboys plus a held redirect
    do_reset();
    bus.init_done_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.attaboy_v_i  = 1'b1;
      bus.attaboy_pc_i = 39'h5000 + VA'(i);
      bus.redir_v_i    = (i == 2);
      bus.redir_pc_i   = 39'h6000;
      #1;
      chk($sformatf("mrst_fill%0d_ayumi", i), 64'(bus.attaboy_yumi_o), 64'(1));
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk("mrst_rst_ayumi", 64'(bus.attaboy_yumi_o), 64'(0));
    chk("mrst_rst_drop",  64'(bus.drop_o), 64'(0));
    tick();
    reset_n          = 1'b1;
    bus.init_done_i  = 1'b0;
    bus.redir_v_i    = 1'b0;
    #1;
    chk("mrst_after_upd_v", 64'(bus.upd_v_o), 64'(0));
    chk("mrst_after_ayumi", 64'(bus.attaboy_yumi_o), 64'(0));
    chk("mrst_after_pc",    64'(bus.upd_pc_o), 64'(0));
    chk("mrst_after_md",    bus.upd_md_o, 64'(0));
    tick();
    bus.init_done_i = 1'b1;
    bus.attaboy_v_i = 1'b0;
    #1;
    chk("mrst_init_upd_v", 64'(bus.upd_v_o), 64'(0));
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.attaboy_v_i = 1'b1;
      #1;
      if (i == 0) chk("mrst_empty_upd_v", 64'(bus.upd_v_o), 64'(0));
      chk($sformatf("mrst_refill%0d_ayumi", i), 64'(bus.attaboy_yumi_o), 64'(i < 4));
      tick();
    end

    // random traffic against the reference model
    do_reset();
    q.delete();
    m_hold_v = 1'b0;
    m_ready  = 1'b0;
    cyc      = 0;
    post_rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      uy_pct = ((n / 500) % 3 == 0) ? 20 : (((n / 500) % 3 == 1) ? 50 : 90);
      reset_n             = ($urandom_range(0, 249) != 0);
      bus.init_done_i     = ($urandom_range(0, 2) != 0);
      bus.redir_v_i       = ($urandom_range(0, 9) < 4);
      bus.redir_taken_i   = $urandom_range(0, 1);
      bus.redir_nonbr_i   = $urandom_range(0, 1);
      r64                 = {$urandom(), $urandom()};
      bus.redir_pc_i      = r64[VA-1:0];
      bus.redir_md_i      = {$urandom(), $urandom()};
      bus.attaboy_v_i     = $urandom_range(0, 1);
      bus.attaboy_taken_i = $urandom_range(0, 1);
      r64                 = {$urandom(), $urandom()};
      bus.attaboy_pc_i    = r64[VA-1:0];
      bus.attaboy_md_i    = {$urandom(), $urandom()};
      bus.upd_yumi_i      = ($urandom_range(0, 99) < uy_pct);
      #1;
      model_cycle(post_rst);
      post_rst = !reset_n;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
